rv32_irq_arbiter: RTL and testbench

- Machine-level external interrupt arbiter (PLIC-lite) between N_SRC peripheral interrupt lines and the core's trap CSR block.
- Gates and latches each source, then selects the highest-priority pending, enabled source above a threshold.
- Drives a single machine external interrupt request to the trap CSR block.
- Software identifies the source through a claim read and retires it through a complete write on a small register bus.

---
 rtl/rv32_irq_arbiter.sv | 121 ++++++++++++
 tb/tb_rv32_irq_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_irq_arbiter.sv
// Machine external interrupt arbiter: per-source gateways, priority selection
// above a threshold, and a claim/complete register interface for software.
module rv32_irq_arbiter #(
   parameter int N_SRC  = 8,
   parameter int PRIO_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             bus_wena,
   input  logic             bus_rena,
   input  logic [7:0]       bus_addr,
   input  logic [31:0]      bus_wdata,
   output logic [31:0]      bus_rdata,
   output logic             bus_rvalid,
   output logic             irq_req
);

   localparam logic [5:0] W_ENABLE    = 6'h20;
   localparam logic [5:0] W_PENDING   = 6'h21;
   localparam logic [5:0] W_THRESHOLD = 6'h22;
   localparam logic [5:0] W_CLAIM     = 6'h23;

   logic [PRIO_W-1:0] prio [N_SRC];
   logic [N_SRC-1:0]  enable;
   logic [N_SRC-1:0]  pending;
   logic [N_SRC-1:0]  in_service;
   logic [PRIO_W-1:0] threshold;

   logic [N_SRC-1:0]  pending_nxt;
   logic [N_SRC-1:0]  in_service_nxt;
   logic [4:0]        best_id;
   logic [PRIO_W-1:0] best_prio;
   logic [31:0]       rd_data;
   logic [5:0]        word;
   logic [7:0]        cpl_id;
   logic              claim;
   logic              complete;
   logic              unused_bits;

   assign word        = bus_addr[7:2];
   assign cpl_id      = bus_wdata[7:0];
   assign claim       = bus_rena && (word == W_CLAIM);
   assign complete    = bus_wena && (word == W_CLAIM);
   assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:8]};

   // Strict '>' while scanning upward keeps the lowest ID on equal priorities.
   // NOTE: combinational blocks use blocking '=' so later loop iterations see
   // the running best; defaults come first so no latch is inferred.
   always_comb begin
      best_id   = '0;
      best_prio = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (pending[i] && enable[i] && (prio[i] > threshold) && (prio[i] > best_prio)) begin
            best_id   = 5'(i + 1);
            best_prio = prio[i];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (word == 6'(i)) rd_data = 32'(prio[i]);
      end
      case (word)
         W_ENABLE:    rd_data = 32'(enable);
         W_PENDING:   rd_data = 32'(pending);
         W_THRESHOLD: rd_data = 32'(threshold);
         W_CLAIM:     rd_data = 32'(best_id);
         default:     ;
      endcase
   end

   // Complete is applied before claim so a same-cycle pair on one ID ends in service.
   always_comb begin
      pending_nxt    = pending | (irq_src & ~in_service);
      in_service_nxt = in_service;
      for (int i = 0; i < N_SRC; i++) begin
         if (complete && (cpl_id == 8'(i + 1))) in_service_nxt[i] = 1'b0;
      end
      for (int i = 0; i < N_SRC; i++) begin
         if (claim && (best_id == 5'(i + 1))) begin
            pending_nxt[i]    = 1'b0;
            in_service_nxt[i] = 1'b1;
         end
      end
   end

   // NOTE: the priority array is a handful of flops that software expects to
   // read as 0 after reset, so it is reset like any other register.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_SRC; i++) prio[i] <= '0;
         enable     <= '0;
         threshold  <= '0;
         pending    <= '0;
         in_service <= '0;
         irq_req    <= 1'b0;
         bus_rdata  <= '0;
         bus_rvalid <= 1'b0;
      end else begin
         pending    <= pending_nxt;
         in_service <= in_service_nxt;
         irq_req    <= (best_id != '0);
         bus_rvalid <= bus_rena;
         if (bus_rena) bus_rdata <= rd_data;
         if (bus_wena) begin
            for (int i = 0; i < N_SRC; i++) begin
               if (word == 6'(i)) prio[i] <= bus_wdata[PRIO_W-1:0];
            end
            case (word)
               W_ENABLE:    enable    <= bus_wdata[N_SRC-1:0];
               W_THRESHOLD: threshold <= bus_wdata[PRIO_W-1:0];
               default:     ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rv32_irq_arbiter.sv
// Bench for rv32_irq_arbiter: directed scenarios with fixed expectations, then
// random traffic compared every cycle against a behavioural model.
module tb_rv32_irq_arbiter;

   localparam int N  = 8;
   localparam int PW = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] irq_src;
   logic         bus_wena;
   logic         bus_rena;
   logic [7:0]   bus_addr;
   logic [31:0]  bus_wdata;
   logic [31:0]  bus_rdata;
   logic         bus_rvalid;
   logic         irq_req;

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   int           m_prio [N];
   logic [N-1:0] m_en, m_pend, m_insvc;
   int           m_thr;
   logic         m_irq, m_rvalid;
   logic [31:0]  m_rdata;

   rv32_irq_arbiter #(.N_SRC(N), .PRIO_W(PW)) dut (
      .clk        (clk),
      .rst        (rst),
      .irq_src    (irq_src),
      .bus_wena   (bus_wena),
      .bus_rena   (bus_rena),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_rdata  (bus_rdata),
      .bus_rvalid (bus_rvalid),
      .irq_req    (irq_req)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Highest priority wins; among equals the smaller ID scores higher.
   function automatic int model_best();
      int best_id    = 0;
      int best_score = -1;
      int score;
      for (int i = 0; i < N; i++) begin
         if (m_pend[i] && m_en[i] && m_prio[i] > m_thr) begin
            score = m_prio[i] * 64 + (63 - (i + 1));
            if (score > best_score) begin
               best_score = score;
               best_id    = i + 1;
            end
         end
      end
      return best_id;
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] a, input int best);
      int w = int'(a[7:2]);
      if (w < N)  return 32'(m_prio[w]);
      if (w == 32) return 32'(m_en);
      if (w == 33) return 32'(m_pend);
      if (w == 34) return 32'(m_thr);
      if (w == 35) return 32'(best);
      return 32'd0;
   endfunction

   task automatic model_edge();
      int           best, w, id;
      logic [31:0]  rv;
      logic [N-1:0] np, ns;
      if (rst) begin
         for (int i = 0; i < N; i++) m_prio[i] = 0;
         m_en = '0; m_pend = '0; m_insvc = '0; m_thr = 0;
         m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
         return;
      end
      best = model_best();
      rv   = model_read(bus_addr, best);
      w    = int'(bus_addr[7:2]);
      np   = m_pend | (irq_src & ~m_insvc);
      ns   = m_insvc;
      if (bus_wena) begin
         if (w < N)   m_prio[w] = int'(bus_wdata[PW-1:0]);
         if (w == 32) m_en = bus_wdata[N-1:0];
         if (w == 34) m_thr = int'(bus_wdata[PW-1:0]);
         if (w == 35) begin
            id = int'(bus_wdata[7:0]);
            if (id >= 1 && id <= N && m_insvc[id-1]) ns[id-1] = 1'b0;
         end
      end
      if (bus_rena && w == 35 && best != 0) begin
         np[best-1] = 1'b0;
         ns[best-1] = 1'b1;
      end
      m_pend   = np;
      m_insvc  = ns;
      m_irq    = (best != 0);
      m_rvalid = bus_rena;
      if (bus_rena) m_rdata = rv;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check("irq_req", 32'(irq_req), 32'(m_irq));
      check("bus_rvalid", 32'(bus_rvalid), 32'(m_rvalid));
      check("bus_rdata", bus_rdata, m_rdata);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      bus_wena = 1'b1; bus_addr = a; bus_wdata = d;
      tick();
      bus_wena = 1'b0;
   endtask

   task automatic rd_expect(input string tag, input logic [7:0] a, input logic [31:0] exp);
      bus_rena = 1'b1; bus_addr = a;
      tick();
      bus_rena = 1'b0;
      check(tag, bus_rdata, exp);
   endtask

   initial begin
      logic [31:0] r;
      int          op;
      logic [7:0]  ra;

      rst = 1'b1; irq_src = '0; bus_wena = 1'b0; bus_rena = 1'b0;
      bus_addr = '0; bus_wdata = '0;
      tick();
      rst = 1'b0;
      check("reset_irq", 32'(irq_req), 32'd0);
      check("reset_rvalid", 32'(bus_rvalid), 32'd0);
      rd_expect("reset_pending", 8'h84, 32'h0);
      rd_expect("reset_enable", 8'h80, 32'h0);

      // Single source, 2-cycle latency, claim
      wr(8'h08, 32'd5); wr(8'h80, 32'h04); wr(8'h88, 32'd0);
      irq_src[2] = 1'b1;
      tick();
      check("t1_irq_n1", 32'(irq_req), 32'd0);
      irq_src[2] = 1'b0;
      rd_expect("t1_pending", 8'h84, 32'h04);
      check("t1_irq_n2", 32'(irq_req), 32'd1);
      rd_expect("t1_enable_lowbits", 8'h83, 32'h04);
      rd_expect("t1_unmapped", 8'h90, 32'h0);
      rd_expect("t1_claim", 8'h8C, 32'd3);
      check("t1_irq_claim_edge", 32'(irq_req), 32'd1);
      tick();
      check("t1_irq_cleared", 32'(irq_req), 32'd0);
      rd_expect("t1_pending_cleared", 8'h84, 32'h0);
      wr(8'h8C, 32'd3);

      // Tie goes to the lowest ID, then a priority raise
      wr(8'h04, 32'd3); wr(8'h10, 32'd3); wr(8'h80, 32'h12);
      irq_src = 8'h12; tick(); irq_src = '0; tick();
      rd_expect("t2_tie_claim", 8'h8C, 32'd2);
      wr(8'h10, 32'd6);
      rd_expect("t2_claim_prio6", 8'h8C, 32'd5);
      wr(8'h8C, 32'd2); wr(8'h8C, 32'd5);

      // Threshold gating
      wr(8'h88, 32'd4); wr(8'h00, 32'd4); wr(8'h80, 32'h01);
      irq_src[0] = 1'b1; tick(); irq_src[0] = 1'b0; tick();
      check("t3_irq_blocked", 32'(irq_req), 32'd0);
      rd_expect("t3_claim_blocked", 8'h8C, 32'd0);
      wr(8'h88, 32'd3);
      check("t3_irq_wr_edge", 32'(irq_req), 32'd0);
      tick();
      check("t3_irq_released", 32'(irq_req), 32'd1);
      rd_expect("t3_claim", 8'h8C, 32'd1);
      wr(8'h8C, 32'd1); wr(8'h88, 32'd0);

      // Held level masked while in service; bad completes ignored
      wr(8'h04, 32'd2); wr(8'h80, 32'h02);
      irq_src[1] = 1'b1; tick(); tick();
      rd_expect("t4_claim", 8'h8C, 32'd2);
      tick(); tick();
      rd_expect("t4_no_repend", 8'h84, 32'h0);
      wr(8'h8C, 32'd9); wr(8'h8C, 32'd4);
      rd_expect("t4_bad_complete", 8'h84, 32'h0);
      rd_expect("t4_claim_none", 8'h8C, 32'd0);
      wr(8'h8C, 32'd2);
      rd_expect("t4_repend_pre", 8'h84, 32'h0);
      rd_expect("t4_repend", 8'h84, 32'h02);
      irq_src[1] = 1'b0;
      rd_expect("t4_claim_again", 8'h8C, 32'd2);
      wr(8'h8C, 32'd2);

      // Empty claim, then same-cycle claim and complete of ID 3
      rd_expect("t5_claim_empty", 8'h8C, 32'd0);
      check("t5_rvalid_pulse", 32'(bus_rvalid), 32'd1);
      tick();
      check("t5_rvalid_drop", 32'(bus_rvalid), 32'd0);
      wr(8'h80, 32'h04);
      irq_src[2] = 1'b1; tick(); tick();
      bus_rena = 1'b1; bus_wena = 1'b1; bus_addr = 8'h8C; bus_wdata = 32'd3;
      tick();
      bus_rena = 1'b0; bus_wena = 1'b0;
      check("t5_dual_claim", bus_rdata, 32'd3);
      tick(); tick();
      rd_expect("t5_still_in_service", 8'h84, 32'h0);
      wr(8'h8C, 32'd3); tick();
      rd_expect("t5_repend", 8'h84, 32'h04);

      // Mid-operation reset
      wr(8'h14, 32'd1); wr(8'h18, 32'd7); wr(8'h80, 32'h64);
      irq_src = 8'h64; tick(); irq_src = 8'h44; tick();
      rd_expect("t6_claim", 8'h8C, 32'd7);
      rst = 1'b1; tick(); rst = 1'b0;
      check("t6_irq", 32'(irq_req), 32'd0);
      check("t6_rdata", bus_rdata, 32'd0);
      check("t6_rvalid", 32'(bus_rvalid), 32'd0);
      rd_expect("t6_pending_pre", 8'h84, 32'h0);
      rd_expect("t6_repend", 8'h84, 32'h44);
      rd_expect("t6_enable", 8'h80, 32'h0);
      rd_expect("t6_prio6", 8'h18, 32'h0);
      rd_expect("t6_threshold", 8'h88, 32'h0);
      irq_src = '0;

      // Random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         bus_wena = 1'b0; bus_rena = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            r = $urandom;
            irq_src = r[N-1:0];
         end
         case ($urandom_range(0, 5))
            0: ra = 8'($urandom_range(0, 31) * 4);
            1: ra = 8'h80;
            2: ra = 8'h84;
            3: ra = 8'h88;
            4: ra = 8'h8C;
            default: ra = 8'($urandom_range(36, 63) * 4 + $urandom_range(0, 3));
         endcase
         op = int'($urandom_range(0, 9));
         r  = $urandom;
         bus_addr  = ra;
         bus_wdata = r;
         case (op)
            0, 1, 2: bus_rena = 1'b1;
            3: begin bus_rena = 1'b1; bus_addr = 8'h8C; end
            4: begin bus_wena = 1'b1; bus_addr = 8'h8C; bus_wdata = 32'($urandom_range(0, 10)); end
            5: begin bus_wena = 1'b1; bus_addr = 8'($urandom_range(0, N - 1) * 4); end
            6: begin
               bus_wena = 1'b1;
               if (r[31]) bus_addr = 8'h80;
               else begin bus_addr = 8'h88; bus_wdata = 32'($urandom_range(0, 3)); end
            end
            7: begin
               bus_rena = 1'b1; bus_wena = 1'b1; bus_addr = 8'h8C;
               bus_wdata = 32'($urandom_range(1, N));
            end
            8: bus_wena = 1'b1;
            default: ;
         endcase
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0; bus_wena = 1'b0; bus_rena = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
